// File: rtl/hx711_rx.sv
// HX711 load-cell ADC receiver: waits for DOUT low, clocks out 24 data bits MSB-first,
// then adds the gain-select pulses that choose the channel/gain of the next conversion.
module hx711_rx #(
   parameter int unsigned CLK_DIV        = 50,
   parameter int unsigned GAIN_PULSES    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 20_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        hx_dout,
   output logic        hx_sclk,
   output logic [23:0] data,
   output logic        done_tick,
   output logic        timeout_tick,
   output logic        ready
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0]      PH_LAST   = 16'(CLK_DIV - 1);
   localparam logic [1:0]       GAIN_LAST = 2'(GAIN_PULSES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_RDY = 3'd1,
      BIT_HI   = 3'd2,
      BIT_LO   = 3'd3,
      GAIN_HI  = 3'd4,
      GAIN_LO  = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic [15:0]       phase_q, phase_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [4:0]        bit_q, bit_d;
   logic [1:0]        gain_q, gain_d;
   logic [23:0]       shift_q, shift_d;
   logic [23:0]       data_q, data_d;
   logic              sclk_q, sclk_d;
   logic              done_q, done_d;
   logic              tmo_tick_q, tmo_tick_d;
   logic              ready_q, ready_d;
   logic              dsync;

   assign dsync = sync2_q;

   // Next-state logic; SCLK and ready are derived from the next state so they stay registered.
   always_comb begin
      state_d    = state_q;
      sync1_d    = hx_dout;
      sync2_d    = sync1_q;
      phase_d    = phase_q;
      tmo_d      = tmo_q;
      bit_d      = bit_q;
      gain_d     = gain_q;
      shift_d    = shift_q;
      data_d     = data_q;
      done_d     = 1'b0;
      tmo_tick_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_RDY;
               tmo_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_RDY: begin
            if (!dsync) begin
               state_d = BIT_HI;
               phase_d = 16'd0;
               bit_d   = 5'd23;
            end else if (tmo_q == TMO_LAST) begin
               state_d    = IDLE;
               tmo_tick_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         BIT_HI: begin
            if (phase_q == PH_LAST) begin
               phase_d = 16'd0;
               shift_d = {shift_q[22:0], dsync};
               state_d = BIT_LO;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         BIT_LO: begin
            if (phase_q == PH_LAST) begin
               phase_d = 16'd0;
               if (bit_q == 5'd0) begin
                  state_d = GAIN_HI;
                  gain_d  = GAIN_LAST;
               end else begin
                  bit_d   = bit_q - 5'd1;
                  state_d = BIT_HI;
               end
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         GAIN_HI: begin
            if (phase_q == PH_LAST) begin
               phase_d = 16'd0;
               state_d = GAIN_LO;
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         GAIN_LO: begin
            if (phase_q == PH_LAST) begin
               phase_d = 16'd0;
               if (gain_q == 2'd0) begin
                  state_d = DONE;
                  data_d  = shift_q;
                  done_d  = 1'b1;
               end else begin
                  gain_d  = gain_q - 2'd1;
                  state_d = GAIN_HI;
               end
            end else begin
               phase_d = phase_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      sclk_d  = (state_d == BIT_HI) || (state_d == GAIN_HI);
      ready_d = (state_d == IDLE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         phase_q    <= 16'd0;
         tmo_q      <= '0;
         bit_q      <= 5'd0;
         gain_q     <= 2'd0;
         shift_q    <= 24'd0;
         data_q     <= 24'd0;
         sclk_q     <= 1'b0;
         done_q     <= 1'b0;
         tmo_tick_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         phase_q    <= phase_d;
         tmo_q      <= tmo_d;
         bit_q      <= bit_d;
         gain_q     <= gain_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         sclk_q     <= sclk_d;
         done_q     <= done_d;
         tmo_tick_q <= tmo_tick_d;
         ready_q    <= ready_d;
      end
   end

   assign hx_sclk      = sclk_q;
   assign data         = data_q;
   assign done_tick    = done_q;
   assign timeout_tick = tmo_tick_q;
   assign ready        = ready_q;

endmodule

// File: tb/tb_hx711_rx.sv
// Bench for hx711_rx: two instances (gain 1 and gain 3) driven by a behavioural HX711 model
// that presents each bit ahead of the sampling point and checks frame shape and captured data.
module tb_hx711_rx;

   localparam int DIV    = 2;
   localparam int GAIN_A = 1;
   localparam int GAIN_B = 3;
   localparam int TMO    = 100;

   logic        clock, reset;
   logic        start_a, start_b, dout_a, dout_b;
   logic        sclk_a, sclk_b, done_a, done_b, tmo_a, tmo_b, ready_a, ready_b;
   logic [23:0] data_a, data_b;

   int n_tests = 0;
   int n_fail  = 0;
   logic [23:0] last_data [2];

   hx711_rx #(.CLK_DIV(DIV), .GAIN_PULSES(GAIN_A), .TIMEOUT_CYCLES(TMO)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .hx_dout(dout_a), .hx_sclk(sclk_a),
      .data(data_a), .done_tick(done_a), .timeout_tick(tmo_a), .ready(ready_a));

   hx711_rx #(.CLK_DIV(DIV), .GAIN_PULSES(GAIN_B), .TIMEOUT_CYCLES(TMO)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .hx_dout(dout_b), .hx_sclk(sclk_b),
      .data(data_b), .done_tick(done_b), .timeout_tick(tmo_b), .ready(ready_b));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          which;
      logic [23:0] sample;
      logic        keep;
      int          exp_pulses;
      logic [23:0] exp_data;
   } vec_t;

   // Reference model: a frame is 24 data pulses plus the gain pulses; data is the raw sample.
   function automatic vec_t mk(input int w, input logic [23:0] s, input logic k);
      vec_t v;
      v.which      = w;
      v.sample     = s;
      v.keep       = k;
      v.exp_pulses = 24 + ((w == 1) ? GAIN_B : GAIN_A);
      v.exp_data   = s;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic sclk_of(input int w);  return (w == 1) ? sclk_b : sclk_a;   endfunction
   function automatic logic ready_of(input int w); return (w == 1) ? ready_b : ready_a; endfunction
   function automatic logic done_of(input int w);  return (w == 1) ? done_b : done_a;   endfunction
   function automatic logic tmo_of(input int w);   return (w == 1) ? tmo_b : tmo_a;     endfunction
   function automatic logic [23:0] data_of(input int w); return (w == 1) ? data_b : data_a; endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 1) start_b = v; else start_a = v;
   endtask

   task automatic set_dout(input int w, input logic v);
      if (w == 1) dout_b = v; else dout_a = v;
   endtask

   task automatic run_frame(input vec_t v, input int rst_at);
      int pulses = 0, falls = 0, hi_run = 0, lo_run = 0, bad_phase = 0;
      int tmo_seen = 0, cyc = 0, wait_cyc = 0, delay, busy = 0, late_done = 0;
      logic s, prev_s = 1'b0, got_done = 1'b0, aborted = 1'b0, rdy1, rdy2;
      logic [23:0] got_data = 24'd0;
      int w = v.which;
      set_start(w, 1'b1);
      set_dout(w, 1'b1);
      @(negedge clock);
      while (ready_of(w) && wait_cyc < 10) begin
         @(negedge clock);
         wait_cyc++;
      end
      check("enter_wait", 32'(ready_of(w)), 32'd0);
      if (!v.keep) set_start(w, 1'b0);
      delay = int'($urandom_range(10, 0));
      repeat (delay) @(negedge clock);
      set_dout(w, 1'b0);
      @(negedge clock);
      set_dout(w, v.sample[23]);
      while (!got_done && !aborted && cyc < 400) begin
         @(negedge clock);
         cyc++;
         s = sclk_of(w);
         if (s && !prev_s) begin
            if (pulses > 0 && lo_run != DIV) bad_phase++;
            pulses++;
            hi_run = 0;
         end
         if (!s && prev_s) begin
            if (hi_run != DIV) bad_phase++;
            lo_run = 0;
            falls++;
            if (falls < 24) set_dout(w, v.sample[23-falls]);
            else set_dout(w, 1'b1);
         end
         if (s) hi_run++; else lo_run++;
         prev_s = s;
         if (tmo_of(w)) tmo_seen++;
         if (done_of(w)) begin
            got_done = 1'b1;
            got_data = data_of(w);
            if (s) bad_phase++;
         end
         if (rst_at != 0 && pulses == rst_at && s) begin
            reset = 1'b1;
            #1;
            check("rst_sclk", 32'(sclk_of(w)), 32'd0);
            check("rst_data", 32'(data_of(w)), 32'd0);
            check("rst_ready", 32'(ready_of(w)), 32'd1);
            check("rst_done", 32'(done_of(w)), 32'd0);
            @(negedge clock);
            @(negedge clock);
            reset = 1'b0;
            set_start(w, 1'b0);
            set_dout(w, 1'b1);
            aborted = 1'b1;
         end
      end
      if (aborted) begin
         last_data[0] = 24'd0;
         last_data[1] = 24'd0;
         repeat (40) begin
            @(negedge clock);
            if (done_of(w) || sclk_of(w) || !ready_of(w)) busy++;
         end
         check("post_reset_quiet", 32'(busy), 32'd0);
         check("post_reset_data", 32'(data_of(w)), 32'd0);
      end else begin
         check("done_seen", 32'(got_done), 32'd1);
         check("pulse_count", 32'(pulses), 32'(v.exp_pulses));
         check("sclk_phase_len", 32'(bad_phase), 32'd0);
         check("data", 32'(got_data), 32'(v.exp_data));
         check("no_timeout", 32'(tmo_seen), 32'd0);
         last_data[w] = v.exp_data;
         @(negedge clock);
         rdy1 = ready_of(w);
         if (done_of(w)) late_done++;
         @(negedge clock);
         rdy2 = ready_of(w);
         if (done_of(w)) late_done++;
         check("idle_after_done", 32'(rdy1), 32'd1);
         check("gap_to_wait", 32'(rdy2), v.keep ? 32'd0 : 32'd1);
         check("single_done", 32'(late_done), 32'd0);
         if (!v.keep) begin
            repeat (8) begin
               @(negedge clock);
               if (!ready_of(w) || sclk_of(w)) busy++;
            end
            check("stays_idle", 32'(busy), 32'd0);
         end
      end
   endtask

   task automatic run_timeout(input logic [23:0] exp_data);
      int cyc = 0, sclk_hi = 0, dones = 0;
      set_dout(0, 1'b1);
      set_start(0, 1'b1);
      @(negedge clock);
      while (ready_a && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      cyc = 0;
      while (!tmo_a && cyc < 300) begin
         @(negedge clock);
         cyc++;
         if (sclk_a) sclk_hi++;
         if (done_a) dones++;
      end
      check("timeout_latency", 32'(cyc), 32'd100);
      check("timeout_data", 32'(data_a), 32'(exp_data));
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
         if (sclk_a) sclk_hi++;
         if (done_a) dones++;
      end while (!tmo_a && cyc < 300);
      check("timeout_repeat", 32'(cyc), 32'd101);
      check("timeout_sclk_low", 32'(sclk_hi), 32'd0);
      check("timeout_no_done", 32'(dones), 32'd0);
      set_start(0, 1'b0);
      cyc = 0;
      while (!ready_a && cyc < 150) begin
         @(negedge clock);
         cyc++;
      end
      check("timeout_back_idle", 32'(ready_a), 32'd1);
   endtask

   vec_t vecs [8];

   initial begin
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      dout_a = 1'b1;  dout_b = 1'b1;
      last_data[0] = 24'd0;
      last_data[1] = 24'd0;
      vecs[0] = mk(0, 24'h800001, 1'b0);
      vecs[1] = mk(1, 24'h7FFFFF, 1'b0);
      vecs[2] = mk(0, 24'h000010, 1'b1);
      vecs[3] = mk(0, 24'hFFFFF0, 1'b0);
      vecs[4] = mk(1, 24'h000000, 1'b0);
      vecs[5] = mk(1, 24'hFFFFFF, 1'b0);
      vecs[6] = mk(0, 24'h555555, 1'b0);
      vecs[7] = mk(1, 24'hAAAAAA, 1'b0);

      repeat (3) @(negedge clock);
      check("reset_sclk", 32'(sclk_a), 32'd0);
      check("reset_data", 32'(data_a), 32'd0);
      check("reset_done", 32'(done_a), 32'd0);
      check("reset_timeout", 32'(tmo_a), 32'd0);
      check("reset_ready", 32'(ready_a), 32'd1);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_no_start", 32'(ready_a), 32'd1);

      for (int i = 0; i < 8; i++) run_frame(vecs[i], 0);

      for (int i = 0; i < 6; i++) begin
         run_frame(mk(int'($urandom_range(1, 0)), 24'($urandom), 1'b0), 0);
      end

      run_frame(mk(0, 24'h123456, 1'b0), 10);
      run_frame(mk(0, 24'hC0FFEE, 1'b0), 0);
      run_frame(mk(1, 24'h3C5A96, 1'b0), 0);

      run_timeout(last_data[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hx711_rx.md
HX711_RX -- requirements
Module: hx711_rx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50, giving the SCLK high-phase and low-phase length in clock cycles (legal range 2..65535).
REQ-002 The block SHALL have parameter GAIN_PULSES, default 1, giving the extra SCLK pulses after the 24 data bits (1 = ch A/128, 2 = ch B/32, 3 = ch A/64; legal range 1..3).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 20_000_000, giving the maximum clock cycles spent waiting for data-ready.
REQ-004 The block SHALL have port clock, input, 1 bit: system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: conversion request, level-sensitive, sampled only in IDLE.
REQ-007 The block SHALL have port hx_dout, input, 1 bit: HX711 DOUT pin, asynchronous to clock.
REQ-008 The block SHALL have port hx_sclk, output, 1 bit: HX711 PD_SCK, registered.
REQ-009 The block SHALL have port data, output, 24 bits: last received sample, raw two's complement, MSB = bit 23.
REQ-010 The block SHALL have port done_tick, output, 1 bit: one-cycle pulse when data updates.
REQ-011 The block SHALL have port timeout_tick, output, 1 bit: one-cycle pulse on ready-wait timeout.
REQ-012 The block SHALL have port ready, output, 1 bit: high only while in IDLE.

Function
REQ-013 The block SHALL pass hx_dout through a 2-flop synchronizer, and all decisions SHALL use only the synchronized value (dsync).
REQ-014 The FSM SHALL have the states IDLE, WAIT_RDY, BIT_HI, BIT_LO, GAIN_HI, GAIN_LO and DONE.
REQ-015 In IDLE with start=1, the FSM SHALL go to WAIT_RDY the next cycle, clear the timeout counter, and drive ready=0 from that cycle onward.
REQ-016 In WAIT_RDY with dsync=0, the FSM SHALL go to BIT_HI with hx_sclk=1 in the following cycle and the bit counter at 23.
REQ-017 WAIT_RDY SHALL otherwise increment the timeout counter, and on reaching TIMEOUT_CYCLES-1 SHALL pulse timeout_tick for 1 cycle and go to IDLE with data unchanged.
REQ-018 BIT_HI SHALL hold hx_sclk=1 for exactly CLK_DIV cycles; on its last cycle it SHALL shift dsync into the shift register at the LSB, MSB-first overall, then go to BIT_LO.
REQ-019 BIT_LO SHALL hold hx_sclk=0 for exactly CLK_DIV cycles, then go to BIT_HI if bits remain, otherwise to GAIN_HI.
REQ-020 GAIN_HI/GAIN_LO SHALL generate exactly GAIN_PULSES pulses with the same timing, ignoring dsync, then go to DONE.
REQ-021 A frame SHALL contain exactly 24+GAIN_PULSES SCLK pulses with 50% duty and period 2*CLK_DIV cycles.
REQ-022 DONE SHALL last 1 cycle: data <= shift register, done_tick=1, hx_sclk=0; the next state SHALL be IDLE.
REQ-023 Back-to-back operation: with start held at 1, the gap from done_tick to the next WAIT_RDY SHALL be exactly 2 cycles (DONE -> IDLE -> WAIT_RDY).
REQ-024 hx_sclk SHALL be 0 in IDLE, WAIT_RDY and DONE, so it never stays high longer than CLK_DIV cycles (prevents HX711 power-down, >60 us).
REQ-025 Deasserting start mid-frame SHALL have no effect; the frame SHALL complete.
REQ-026 done_tick and timeout_tick SHALL never be asserted in the same cycle.
REQ-027 Phase and timeout counters SHALL be wide enough for the parameter maxima with no wrap-around.

Reset
REQ-028 On reset assertion the block SHALL immediately force state=IDLE, hx_sclk=0, data=0, done_tick=0, timeout_tick=0, ready=1, and clear all counters, the shift register and the synchronizer.
REQ-029 Reset mid-frame SHALL abort the frame with no done_tick, and data SHALL be 0.
REQ-030 After reset release, the first frame SHALL start only via IDLE -> WAIT_RDY.

Verification
REQ-031 CLK_DIV=2, GAIN_PULSES=1, model drives 0x800001, dout low -> 25 SCLK pulses of 4-cycle period; data=0x800001; one done_tick.
REQ-032 GAIN_PULSES=3, model drives 0x7FFFFF -> 27 pulses; data=0x7FFFFF; no SCLK high phase longer than 2 cycles.
REQ-033 TIMEOUT_CYCLES=100, hx_dout held 1, start=1 -> timeout_tick exactly 100 cycles after entering WAIT_RDY; hx_sclk stays 0; data unchanged; repeats while start=1.
REQ-034 Reset asserted during bit 10 of a frame -> hx_sclk=0 and data=0 the same cycle; no done_tick; the next frame after release captures correctly.
REQ-035 start held 1, two consecutive samples 0x000010 then 0xFFFFF0 -> two done_ticks; data sequence 0x000010, 0xFFFFF0; exactly 2 cycles from done_tick to WAIT_RDY.
REQ-036 start pulsed 1 cycle then deasserted mid-frame -> frame completes; the block returns to IDLE and stays there with ready=1.
